avmm_master_arbiter: RTL and testbench

- Shares one Avalon-MM master port between NUM_REQ requesters, e.g. the projection engine's mean/face/eigenvector loaders and the projection-result writer.
- Grants commands using round-robin arbitration.
- Holds each granted command stable across master_waitrequest.
- Tracks pipelined reads in a tag FIFO, so each master_readdatavalid beat is routed back to the requester that issued the read.
- Sits between the requester blocks and the Qsys master interface.

---
 rtl/avmm_arb_pkg.sv | 25 ++
 rtl/rd_tag_fifo.sv | 48 ++++
 rtl/avmm_master_arbiter.sv | 128 ++++++++++++
 tb/tb_avmm_master_arbiter.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/avmm_arb_pkg.sv
// Shared types and the round-robin pick helper for the Avalon-MM master arbiter.
package avmm_arb_pkg;

  typedef enum logic {IDLE, ISSUE} state_t;

  localparam int RR_MAX = 8;

  // Index of the first set bit at or above ptr, wrapping at n; returns ptr when nothing is set.
  function automatic logic [2:0] rr_pick(input logic [RR_MAX-1:0] req_vec,
                                         input logic [2:0]        ptr,
                                         input int                n);
    logic [2:0] pick;
    int         idx;
    pick = ptr;
    for (int k = RR_MAX - 1; k >= 0; k--) begin
      if (k < n) begin
        idx = int'(ptr) + k;
        if (idx >= n) idx = idx - n;
        if (req_vec[idx]) pick = 3'(idx);
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/rd_tag_fifo.sv
// Requester-id FIFO for outstanding reads; a pop frees a slot, so push+pop while full is legal.
module rd_tag_fifo #(
  parameter  int WIDTH = 2,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign head    = mem_q[rd_ptr_q];
  assign count   = count_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  // Tag storage needs no reset; entries are only read behind a valid count.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/avmm_master_arbiter.sv
// Round-robin arbiter sharing one Avalon-MM master among NUM_REQ requesters, with read-tag routing.
// IDLE: pick next eligible requester | ISSUE: drive granted command until the fabric accepts it
module avmm_master_arbiter
  import avmm_arb_pkg::*;
#(
  parameter  int NUM_REQ      = 3,
  parameter  int ADDRESSWIDTH = 28,
  parameter  int DATAWIDTH    = 32,
  parameter  int MAX_PENDING  = 4,
  localparam int ID_W         = $clog2(NUM_REQ),
  localparam int CNT_W        = $clog2(MAX_PENDING) + 1
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic [NUM_REQ-1:0][ADDRESSWIDTH-1:0]   req_address,
  input  logic [NUM_REQ-1:0][DATAWIDTH-1:0]      req_writedata,
  input  logic [NUM_REQ-1:0]                     req_read,
  input  logic [NUM_REQ-1:0]                     req_write,
  output logic [NUM_REQ-1:0]                     req_waitrequest,
  output logic [DATAWIDTH-1:0]                   req_readdata,
  output logic [NUM_REQ-1:0]                     req_readdatavalid,
  output logic [ADDRESSWIDTH-1:0]                master_address,
  output logic [DATAWIDTH-1:0]                   master_writedata,
  output logic                                   master_read,
  output logic                                   master_write,
  input  logic [DATAWIDTH-1:0]                   master_readdata,
  input  logic                                   master_readdatavalid,
  input  logic                                   master_waitrequest,
  output logic [ID_W-1:0]                        grant_id,
  output logic [CNT_W-1:0]                       pending_count,
  output logic                                   err_unexpected_rdv
);

  state_t            state_q, state_d;
  logic [ID_W-1:0]   grant_q, grant_d, rr_ptr_q, rr_ptr_d;
  logic              wr_cmd_q, wr_cmd_d;
  logic              err_q, err_d;
  logic [NUM_REQ-1:0] eligible;
  logic              accept, push, pop;
  logic              fifo_full, fifo_empty;
  logic [ID_W-1:0]   fifo_head;

  assign eligible = req_write | (req_read & {NUM_REQ{~fifo_full}});

  always_comb begin
    state_d          = state_q;
    grant_d          = grant_q;
    rr_ptr_d         = rr_ptr_q;
    wr_cmd_d         = wr_cmd_q;
    accept           = 1'b0;
    master_address   = '0;
    master_writedata = '0;
    master_read      = 1'b0;
    master_write     = 1'b0;
    case (state_q)
      IDLE: begin
        if (|eligible) begin
          grant_d  = ID_W'(rr_pick(8'(eligible), 3'(rr_ptr_q), NUM_REQ));
          wr_cmd_d = req_write[grant_d];
          state_d  = ISSUE;
        end
      end
      ISSUE: begin
        // Command type is latched at grant so a dropped request still issues as granted.
        master_address   = req_address[grant_q];
        master_writedata = req_writedata[grant_q];
        master_write     = wr_cmd_q;
        master_read      = ~wr_cmd_q;
        if (!master_waitrequest) begin
          accept   = 1'b1;
          rr_ptr_d = (grant_q == ID_W'(NUM_REQ - 1)) ? '0 : grant_q + ID_W'(1);
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign push  = accept & ~wr_cmd_q;
  assign pop   = master_readdatavalid & ~fifo_empty;
  assign err_d = err_q | (master_readdatavalid & fifo_empty);

  always_comb begin
    req_waitrequest = '1;
    if (accept) req_waitrequest[grant_q] = 1'b0;
  end

  always_comb begin
    req_readdatavalid = '0;
    if (pop) req_readdatavalid[fifo_head] = 1'b1;
  end

  assign req_readdata       = master_readdata;
  assign grant_id           = grant_q;
  assign err_unexpected_rdv = err_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      rr_ptr_q <= '0;
      wr_cmd_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
      wr_cmd_q <= wr_cmd_d;
      err_q    <= err_d;
    end
  end

  rd_tag_fifo #(
    .WIDTH (ID_W),
    .DEPTH (MAX_PENDING)
  ) u_tag_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (grant_q),
    .pop       (pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (pending_count)
  );

endmodule

// File: tb/tb_avmm_master_arbiter.sv
// Directed and randomized bench for avmm_master_arbiter against a transaction-level model.
module tb_avmm_master_arbiter;

  localparam int NR  = 3;
  localparam int AWD = 28;
  localparam int DW  = 32;
  localparam int MP  = 4;

  logic                    clk = 1'b0;
  logic                    reset;
  logic [NR-1:0][AWD-1:0]  req_address;
  logic [NR-1:0][DW-1:0]   req_writedata;
  logic [NR-1:0]           req_read, req_write, req_waitrequest, req_readdatavalid;
  logic [DW-1:0]           req_readdata;
  logic [AWD-1:0]          master_address;
  logic [DW-1:0]           master_writedata, master_readdata;
  logic                    master_read, master_write, master_readdatavalid, master_waitrequest;
  logic [1:0]              grant_id;
  logic [2:0]              pending_count;
  logic                    err_unexpected_rdv;

  avmm_master_arbiter #(
    .NUM_REQ(NR), .ADDRESSWIDTH(AWD), .DATAWIDTH(DW), .MAX_PENDING(MP)
  ) dut (
    .clk                 (clk),
    .reset               (reset),
    .req_address         (req_address),
    .req_writedata       (req_writedata),
    .req_read            (req_read),
    .req_write           (req_write),
    .req_waitrequest     (req_waitrequest),
    .req_readdata        (req_readdata),
    .req_readdatavalid   (req_readdatavalid),
    .master_address      (master_address),
    .master_writedata    (master_writedata),
    .master_read         (master_read),
    .master_write        (master_write),
    .master_readdata     (master_readdata),
    .master_readdatavalid(master_readdatavalid),
    .master_waitrequest  (master_waitrequest),
    .grant_id            (grant_id),
    .pending_count       (pending_count),
    .err_unexpected_rdv  (err_unexpected_rdv)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;
  int q[$];          // model: requester ids of outstanding reads, oldest first
  bit m_err;
  int mode[NR];      // 0 one-shot, 1 continuous write, 2 continuous read, 3 random
  int waited[NR];    // other-requester accepts seen while a write is pending
  int last_acc;
  bit rnd;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic new_cmd(input int i, input bit rd, input bit wr);
    req_address[i]   = AWD'($urandom);
    req_writedata[i] = $urandom;
    req_read[i]      = rd;
    req_write[i]     = wr;
    waited[i]        = 0;
  endtask

  task automatic do_reset(input bit check);
    reset = 1'b1;
    req_address = '0; req_writedata = '0; req_read = '0; req_write = '0;
    master_readdata = '0; master_readdatavalid = 1'b0; master_waitrequest = 1'b0;
    q.delete(); m_err = 1'b0; last_acc = -1; rnd = 1'b0;
    for (int i = 0; i < NR; i++) begin mode[i] = 0; waited[i] = 0; end
    repeat (2) @(posedge clk);
    @(negedge clk);
    if (check) begin
      chk("rst_waitreq", req_waitrequest, 3'b111);
      chk("rst_mread", master_read, 1'b0);
      chk("rst_mwrite", master_write, 1'b0);
      chk("rst_maddr", master_address, '0);
      chk("rst_rdv", req_readdatavalid, 3'b000);
      chk("rst_grant", grant_id, 2'd0);
      chk("rst_pending", pending_count, 3'd0);
      chk("rst_err", err_unexpected_rdv, 1'b0);
    end
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  // Mid-cycle sample: checks this cycle against the model and records any acceptance.
  task automatic sample(output int acc);
    int            hits;
    logic [NR-1:0] exp_rdv;
    @(negedge clk);
    acc = -1; hits = 0; exp_rdv = '0;
    for (int i = 0; i < NR; i++)
      if (req_waitrequest[i] === 1'b0) begin acc = i; hits++; end
    chk("multi_accept", hits > 1, 1'b0);
    chk("pending_count", pending_count, q.size());
    chk("err_flag", err_unexpected_rdv, m_err);
    if (master_readdatavalid) begin
      if (q.size() > 0) begin
        exp_rdv[q[0]] = 1'b1;
        void'(q.pop_front());
        chk("readdata", req_readdata, master_readdata);
      end else begin
        m_err = 1'b1;
      end
    end
    chk("rdv_route", req_readdatavalid, exp_rdv);
    if (acc >= 0) begin
      chk("acc_has_cmd", req_read[acc] | req_write[acc], 1'b1);
      chk("acc_no_wait", master_waitrequest, 1'b0);
      chk("acc_addr", master_address, req_address[acc]);
      chk("acc_cmd", {master_write, master_read}, req_write[acc] ? 2'b10 : 2'b01);
      if (req_write[acc]) begin
        chk("acc_wdata", master_writedata, req_writedata[acc]);
        chk("rr_bound", waited[acc] <= NR - 1, 1'b1);
      end else begin
        q.push_back(acc);
        chk("no_overflow", q.size() <= MP, 1'b1);
      end
      for (int j = 0; j < NR; j++)
        if (j != acc && req_write[j]) waited[j]++;
      waited[acc] = 0;
    end
    last_acc = acc;
  endtask

  task automatic advance();
    int i, r;
    @(posedge clk); #1;
    master_readdatavalid = 1'b0;
    if (last_acc >= 0) begin
      i = last_acc;
      req_read[i] = 1'b0; req_write[i] = 1'b0;
      if (mode[i] == 1) new_cmd(i, 1'b0, 1'b1);
      else if (mode[i] == 2) new_cmd(i, 1'b1, 1'b0);
    end
    last_acc = -1;
    if (rnd) begin
      for (int j = 0; j < NR; j++)
        if (mode[j] == 3 && !req_read[j] && !req_write[j] && $urandom_range(0, 2) == 0) begin
          r = $urandom_range(0, 3);
          new_cmd(j, r != 2, r >= 2);
        end
      master_waitrequest = ($urandom_range(0, 2) == 0);
      if (q.size() > 0 && $urandom_range(0, 2) == 0) begin
        master_readdatavalid = 1'b1;
        master_readdata      = $urandom;
      end
    end
  endtask

  task automatic drain();
    int acc;
    for (int i = 0; i < NR; i++) mode[i] = 0;
    rnd = 1'b0;
    master_waitrequest = 1'b0;
    for (int k = 0; k < 80; k++) begin
      if (q.size() == 0 && req_read == '0 && req_write == '0) break;
      if (q.size() > 0) begin
        master_readdatavalid = 1'b1;
        master_readdata      = $urandom;
      end
      sample(acc);
      advance();
    end
    chk("drain_done", q.size() == 0 && req_read == '0 && req_write == '0, 1'b1);
    chk("drain_pending", pending_count, 3'd0);
  endtask

  task automatic issue_one(input int i, input bit wr);
    int acc;
    bit done;
    new_cmd(i, !wr, wr);
    done = 1'b0;
    for (int k = 0; k < 20; k++) begin
      sample(acc);
      if (acc == i) done = 1'b1;
      advance();
      if (done) break;
    end
    chk("issue_timeout", done, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int            acc, c0, c2;
    int            order[$];
    int            wc0[NR], wc1[NR];
    logic [DW-1:0] wdat;
    logic [NR-1:0] exp_seq [3];

    do_reset(1'b1);

    // Single reader
    req_read[0] = 1'b1; req_address[0] = 28'h0800000;
    sample(acc);
    chk("t1_idle_mread", master_read, 1'b0);
    chk("t1_no_acc", acc < 0, 1'b1);
    advance();
    sample(acc);
    chk("t1_mread", master_read, 1'b1);
    chk("t1_maddr", master_address, 28'h0800000);
    chk("t1_waitreq", req_waitrequest, 3'b110);
    chk("t1_acc", acc, 0);
    advance();
    sample(acc);
    chk("t1_pending1", pending_count, 3'd1);
    advance(); sample(acc); advance();
    master_readdatavalid = 1'b1; master_readdata = 32'h1234;
    sample(acc);
    chk("t1_rdv", req_readdatavalid, 3'b001);
    chk("t1_rdata", req_readdata, 32'h1234);
    advance();
    sample(acc);
    chk("t1_pending0", pending_count, 3'd0);
    advance();

    // Round robin with all three writing continuously
    do_reset(1'b0);
    for (int i = 0; i < NR; i++) begin mode[i] = 1; new_cmd(i, 1'b0, 1'b1); wc0[i] = 0; wc1[i] = 0; end
    for (int k = 0; k < 12; k++) begin
      sample(acc);
      if (acc >= 0) begin
        order.push_back(acc);
        if (k < 6) wc0[acc]++; else wc1[acc]++;
        chk("rr_odd_cycle", k % 2, 1);
      end
      advance();
    end
    chk("rr_count", order.size(), 6);
    for (int k = 0; k < order.size(); k++) chk("rr_order", order[k], k % NR);
    for (int i = 0; i < NR; i++) begin
      chk("rr_win0", wc0[i], 1);
      chk("rr_win1", wc1[i], 1);
    end
    drain();

    // Waitrequest stall on a requester-1 write
    do_reset(1'b0);
    new_cmd(1, 1'b0, 1'b1);
    req_address[1] = 28'h960D100;
    wdat = req_writedata[1];
    master_waitrequest = 1'b1;
    sample(acc); advance();
    req_write[0] = 1'b1; req_write[2] = 1'b1;
    for (int k = 0; k < 5; k++) begin
      sample(acc);
      chk("stall_mwrite", master_write, 1'b1);
      chk("stall_addr", master_address, 28'h960D100);
      chk("stall_data", master_writedata, wdat);
      chk("stall_waitreq", req_waitrequest, 3'b111);
      chk("stall_grant", grant_id, 2'd1);
      advance();
    end
    master_waitrequest = 1'b0;
    sample(acc);
    chk("stall_accept", acc, 1);
    chk("stall_wr_low", req_waitrequest, 3'b101);
    advance();
    sample(acc); advance();
    sample(acc);
    chk("stall_next_grant", grant_id, 2'd2);
    chk("stall_next_acc", acc, 2);
    advance();
    drain();

    // FIFO full: reads withheld, writes still proceed
    do_reset(1'b0);
    mode[0] = 2; new_cmd(0, 1'b1, 1'b0);
    c0 = 0;
    for (int k = 0; k < 10; k++) begin sample(acc); if (acc == 0) c0++; advance(); end
    chk("full_reads", c0, 4);
    chk("full_pending", pending_count, 3'd4);
    new_cmd(2, 1'b0, 1'b1);
    c0 = 0; c2 = 0;
    for (int k = 0; k < 4; k++) begin
      sample(acc);
      if (acc == 0) c0++;
      if (acc == 2) c2++;
      advance();
    end
    chk("full_write_issued", c2, 1);
    chk("full_read_withheld", c0, 0);
    master_readdatavalid = 1'b1; master_readdata = $urandom;
    sample(acc);
    chk("full_rdv", req_readdatavalid, 3'b001);
    advance();
    c0 = 0;
    for (int k = 0; k < 4; k++) begin sample(acc); if (acc == 0) c0++; advance(); end
    chk("full_fifth_read", c0, 1);
    drain();

    // Interleaved read routing
    do_reset(1'b0);
    issue_one(2, 1'b0); issue_one(0, 1'b0); issue_one(1, 1'b0);
    exp_seq[0] = 3'b100; exp_seq[1] = 3'b001; exp_seq[2] = 3'b010;
    for (int k = 0; k < 3; k++) begin
      master_readdatavalid = 1'b1; master_readdata = $urandom;
      sample(acc);
      chk("route_seq", req_readdatavalid, exp_seq[k]);
      advance();
    end
    chk("route_pending0", pending_count, 3'd0);

    // Reset with reads in flight, then stale responses
    do_reset(1'b0);
    issue_one(0, 1'b0); issue_one(1, 1'b0);
    chk("spur_pending2", pending_count, 3'd2);
    do_reset(1'b0);
    for (int k = 0; k < 2; k++) begin
      master_readdatavalid = 1'b1; master_readdata = $urandom;
      sample(acc);
      chk("spur_no_rdv", req_readdatavalid, 3'b000);
      advance();
    end
    chk("spur_err", err_unexpected_rdv, 1'b1);
    chk("spur_pending0", pending_count, 3'd0);

    // Randomized traffic
    do_reset(1'b0);
    rnd = 1'b1;
    for (int i = 0; i < NR; i++) mode[i] = 3;
    repeat (400) begin sample(acc); advance(); end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
